// File: rtl/c1581_rom_arb.sv
// Shares one ROM between NDR drives: each ph2_f strobe reads one byte per drive
// in turn, and loader writes are slotted into idle cycles.
module c1581_rom_arb #(
  parameter  int unsigned NDR     = 2,
  parameter  int unsigned ROM_LAT = 1,
  localparam int unsigned AW      = 15,
  localparam int unsigned DW      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ph2_f,
  input  logic [NDR-1:0][AW-1:0]  drv_addr,
  output logic [NDR-1:0][DW-1:0]  drv_data,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_din,
  output logic                    mem_we,
  input  logic [DW-1:0]           mem_dout,
  input  logic [AW-1:0]           ld_addr,
  input  logic [DW-1:0]           ld_data,
  input  logic                    ld_wr,
  output logic                    ld_busy,
  output logic                    seq_err
);

  localparam int unsigned LAST = NDR + ROM_LAT;
  localparam int unsigned SW   = $clog2(LAST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEQ   = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [SW-1:0]             step_q, step_d;
  logic [AW-1:0]             mem_addr_q, mem_addr_d;
  logic [DW-1:0]             mem_din_q, mem_din_d;
  logic                      mem_we_q, mem_we_d;
  logic [NDR-1:0][DW-1:0]    drv_data_q, drv_data_d;
  logic [AW-1:0]             buf_addr_q, buf_addr_d;
  logic [DW-1:0]             buf_data_q, buf_data_d;
  logic                      ld_busy_q, ld_busy_d;
  logic                      seq_err_q, seq_err_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      drv_data_q <= '0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      ld_busy_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      drv_data_q <= drv_data_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      ld_busy_q  <= ld_busy_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    drv_data_d = drv_data_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    ld_busy_d  = ld_busy_q;
    seq_err_d  = 1'b0;

    if (ld_wr && !ld_busy_q) begin
      buf_addr_d = ld_addr;
      buf_data_d = ld_data;
      ld_busy_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!ph2_f && ld_busy_q) begin
          state_d    = ST_WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = buf_addr_q;
          mem_din_d  = buf_data_q;
        end
      end
      ST_SEQ: begin
        for (int unsigned k = 0; k < NDR; k++) begin
          if (step_q == SW'(k)) mem_addr_d = drv_addr[k];
        end
        // Data for drive k returns ROM_LAT+1 steps after its address step
        for (int unsigned k = 0; k < NDR; k++) begin
          if (step_q == SW'(k + 1 + ROM_LAT)) drv_data_d[k] = mem_dout;
        end
        if (step_q == SW'(LAST)) state_d = ST_IDLE;
        else                     step_d  = step_q + SW'(1);
        seq_err_d = ph2_f;
      end
      ST_WRITE: begin
        ld_busy_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe always wins: restart the read sequence from step 0
    if (ph2_f) begin
      state_d = ST_SEQ;
      step_d  = '0;
    end
  end

  assign drv_data = drv_data_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign ld_busy  = ld_busy_q;
  assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_c1581_rom_arb.sv
// Bench for c1581_rom_arb: a 2-drive/latency-1 instance with loader traffic and
// a 4-drive/latency-2 read-only instance, both against behavioural ROM models.
module tb_c1581_rom_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Instance A: NDR=2, ROM_LAT=1
  logic             ph2_f_a;
  logic [1:0][14:0] drv_addr_a;
  logic [1:0][7:0]  drv_data_a;
  logic [14:0]      mem_addr_a;
  logic [7:0]       mem_din_a;
  logic             mem_we_a;
  logic [7:0]       mem_dout_a;
  logic [14:0]      ld_addr_a;
  logic [7:0]       ld_data_a;
  logic             ld_wr_a;
  logic             ld_busy_a;
  logic             seq_err_a;

  c1581_rom_arb #(.NDR(2), .ROM_LAT(1)) u_a (
    .clk(clk), .reset(reset), .ph2_f(ph2_f_a),
    .drv_addr(drv_addr_a), .drv_data(drv_data_a),
    .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a), .mem_dout(mem_dout_a),
    .ld_addr(ld_addr_a), .ld_data(ld_data_a), .ld_wr(ld_wr_a),
    .ld_busy(ld_busy_a), .seq_err(seq_err_a)
  );

  // Instance B: NDR=4, ROM_LAT=2, no loader
  logic             ph2_f_b;
  logic [3:0][14:0] drv_addr_b;
  logic [3:0][7:0]  drv_data_b;
  logic [14:0]      mem_addr_b;
  logic [7:0]       mem_din_b;
  logic             mem_we_b;
  logic [7:0]       mem_dout_b;
  logic [7:0]       pipe_b;
  logic             ld_busy_b;
  logic             seq_err_b;

  c1581_rom_arb #(.NDR(4), .ROM_LAT(2)) u_b (
    .clk(clk), .reset(reset), .ph2_f(ph2_f_b),
    .drv_addr(drv_addr_b), .drv_data(drv_data_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b), .mem_dout(mem_dout_b),
    .ld_addr(15'h0000), .ld_data(8'h00), .ld_wr(1'b0),
    .ld_busy(ld_busy_b), .seq_err(seq_err_b)
  );

  function automatic logic [7:0] rom_init(input logic [14:0] a);
    return 8'(a * 15'd37) ^ 8'(a >> 7) ^ 8'h5A;
  endfunction

  // ROM models: fixed contents plus a write overlay for A
  logic [7:0] wmem_a [logic [14:0]];
  always @(posedge clk) begin
    mem_dout_a <= wmem_a.exists(mem_addr_a) ? wmem_a[mem_addr_a] : rom_init(mem_addr_a);
    if (mem_we_a) wmem_a[mem_addr_a] = mem_din_a;
  end
  always @(posedge clk) begin
    pipe_b     <= rom_init(mem_addr_b);
    mem_dout_b <= pipe_b;
  end

  // Reference: what the ROM should hold, updated only by the bench's own writes
  logic [7:0] ref_a [logic [14:0]];
  function automatic logic [7:0] ref_rd(input logic [14:0] a);
    if (ref_a.exists(a)) return ref_a[a];
    return rom_init(a);
  endfunction

  logic [7:0] exp_a [2];
  logic [7:0] exp_b [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr_a"}, 32'(mem_addr_a), 32'h0);
    chk({tag, "_din_a"},  32'(mem_din_a),  32'h0);
    chk({tag, "_we_a"},   32'(mem_we_a),   32'h0);
    chk({tag, "_data_a"}, 32'(drv_data_a), 32'h0);
    chk({tag, "_busy_a"}, 32'(ld_busy_a),  32'h0);
    chk({tag, "_err_a"},  32'(seq_err_a),  32'h0);
    chk({tag, "_addr_b"}, 32'(mem_addr_b), 32'h0);
    chk({tag, "_data_b"}, 32'(drv_data_b), 32'h0);
    chk({tag, "_we_b"},   32'(mem_we_b),   32'h0);
  endtask

  // One read sequence on A, optionally with a coincident loader write
  task automatic run_seq_a(input string tag, input logic [14:0] a0, input logic [14:0] a1,
                           input bit with_ld, input logic [14:0] la, input logic [7:0] ldd);
    logic [7:0] e0, e1;
    int seen;
    e0 = ref_rd(a0);
    e1 = ref_rd(a1);
    drv_addr_a = {a1, a0};
    ph2_f_a = 1'b1;
    if (with_ld) begin
      ld_wr_a = 1'b1; ld_addr_a = la; ld_data_a = ldd;
    end
    tick();
    ph2_f_a = 1'b0;
    ld_wr_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_we_in_seq"}, 32'(mem_we_a), 32'h0);
      tick();
    end
    chk({tag, "_d0"}, 32'(drv_data_a[0]), 32'(e0));
    chk({tag, "_d1"}, 32'(drv_data_a[1]), 32'(e1));
    exp_a[0] = e0;
    exp_a[1] = e1;
    if (with_ld) begin
      seen = 0;
      for (int i = 0; i < 3; i++) begin
        if (mem_we_a) begin
          seen++;
          chk({tag, "_wr_addr"}, 32'(mem_addr_a), 32'(la));
          chk({tag, "_wr_din"},  32'(mem_din_a),  32'(ldd));
        end
        tick();
      end
      chk({tag, "_wr_count"}, 32'(seen), 32'h1);
      chk({tag, "_busy_clr"}, 32'(ld_busy_a), 32'h0);
      ref_a[la] = ldd;
    end
  endtask

  // One read sequence on B: 7 cycles, data for drive k lands at t+5+k
  task automatic run_seq_b(input string tag, input logic [3:0][14:0] ad);
    drv_addr_b = ad;
    ph2_f_b = 1'b1;
    tick();
    ph2_f_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk({tag, "_we"}, 32'(mem_we_b), 32'h0);
      if (i >= 1 && i <= 4) chk({tag, "_addr"}, 32'(mem_addr_b), 32'(ad[i-1]));
      if (i == 6) chk({tag, "_d3_early"}, 32'(drv_data_b[3]), 32'(exp_b[3]));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      exp_b[k] = rom_init(ad[k]);
      chk({tag, "_data"}, 32'(drv_data_b[k]), 32'(exp_b[k]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] a0, a1, la;
    logic [7:0]  ldd;
    logic [3:0][14:0] adb;
    int mode, n;

    reset = 1'b1;
    ph2_f_a = 1'b0; ph2_f_b = 1'b0; ld_wr_a = 1'b0;
    ld_addr_a = '0; ld_data_a = '0;
    drv_addr_a = {15'h0123, 15'h0456};
    drv_addr_b = '0;
    exp_a[0] = 8'h00; exp_a[1] = 8'h00;
    for (int k = 0; k < 4; k++) exp_b[k] = 8'h00;
    #1;
    tick();
    ph2_f_a = 1'b1; ld_wr_a = 1'b1; ld_addr_a = 15'h0042; ld_data_a = 8'h99;
    tick();
    ph2_f_a = 1'b0; ld_wr_a = 1'b0;
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();
    chk("post_rst_we", 32'(mem_we_a), 32'h0);

    // Basic read: address and data timing relative to the strobe
    drv_addr_a = {15'h7FFF, 15'h0010};
    ph2_f_a = 1'b1;
    tick();
    ph2_f_a = 1'b0;
    chk("basic_we_t1", 32'(mem_we_a), 32'h0);
    tick();
    chk("basic_addr_t2", 32'(mem_addr_a), 32'h0010);
    tick();
    chk("basic_addr_t3", 32'(mem_addr_a), 32'h7FFF);
    chk("basic_d0_t3", 32'(drv_data_a[0]), 32'h0);
    tick();
    chk("basic_d0_t4", 32'(drv_data_a[0]), 32'(ref_rd(15'h0010)));
    tick();
    chk("basic_d1_t5", 32'(drv_data_a[1]), 32'(ref_rd(15'h7FFF)));
    chk("basic_d0_t5", 32'(drv_data_a[0]), 32'(ref_rd(15'h0010)));
    tick();
    chk("basic_addr_hold", 32'(mem_addr_a), 32'h7FFF);
    exp_a[0] = ref_rd(15'h0010);
    exp_a[1] = ref_rd(15'h7FFF);

    // Loader write in idle, with a second request ignored while busy
    ld_wr_a = 1'b1; ld_addr_a = 15'h1234; ld_data_a = 8'hA5;
    tick();
    ld_addr_a = 15'h0777; ld_data_a = 8'h11;
    chk("wr_busy_set", 32'(ld_busy_a), 32'h1);
    chk("wr_we_early", 32'(mem_we_a), 32'h0);
    tick();
    ld_wr_a = 1'b0;
    chk("wr_we", 32'(mem_we_a), 32'h1);
    chk("wr_addr", 32'(mem_addr_a), 32'h1234);
    chk("wr_din", 32'(mem_din_a), 32'hA5);
    chk("wr_busy_hold", 32'(ld_busy_a), 32'h1);
    tick();
    chk("wr_we_off", 32'(mem_we_a), 32'h0);
    chk("wr_busy_clr", 32'(ld_busy_a), 32'h0);
    tick();
    chk("wr_no_second", 32'(mem_we_a), 32'h0);
    ref_a[15'h1234] = 8'hA5;
    run_seq_a("readback", 15'h1234, 15'h0010, 1'b0, '0, '0);
    chk("readback_const", 32'(drv_data_a[0]), 32'hA5);

    // Loader write coincident with the strobe: read sees old data, write follows
    run_seq_a("coinc", 15'h0300, 15'h0301, 1'b1, 15'h0300, 8'h5C);
    run_seq_a("coinc_rd", 15'h0301, 15'h0300, 1'b0, '0, '0);

    // Overrun: second strobe two cycles after the first
    drv_addr_a = {15'h0200, 15'h0100};
    ph2_f_a = 1'b1;
    tick();
    ph2_f_a = 1'b0;
    chk("ovr_err_t1", 32'(seq_err_a), 32'h0);
    tick();
    chk("ovr_err_t2", 32'(seq_err_a), 32'h0);
    ph2_f_a = 1'b1;
    tick();
    ph2_f_a = 1'b0;
    chk("ovr_err_pulse", 32'(seq_err_a), 32'h1);
    drv_addr_a = {15'h0400, 15'h0500};
    tick();
    chk("ovr_err_clr", 32'(seq_err_a), 32'h0);
    chk("ovr_addr_restart", 32'(mem_addr_a), 32'h0500);
    tick();
    chk("ovr_d0_hold", 32'(drv_data_a[0]), 32'(exp_a[0]));
    chk("ovr_d1_hold", 32'(drv_data_a[1]), 32'(exp_a[1]));
    tick();
    chk("ovr_d0_new", 32'(drv_data_a[0]), 32'(ref_rd(15'h0500)));
    chk("ovr_d1_still", 32'(drv_data_a[1]), 32'(exp_a[1]));
    tick();
    chk("ovr_d1_new", 32'(drv_data_a[1]), 32'(ref_rd(15'h0400)));
    exp_a[0] = ref_rd(15'h0500);
    exp_a[1] = ref_rd(15'h0400);

    // Randomized traffic on A over a small address window so writes get read back
    for (int it = 0; it < 24; it++) begin
      mode = int'($urandom_range(0, 2));
      a0  = 15'($urandom_range(0, 15));
      a1  = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15));
      la  = 15'($urandom_range(0, 15));
      ldd = 8'($urandom);
      if (mode == 2) begin
        ld_wr_a = 1'b1; ld_addr_a = la; ld_data_a = ldd;
        tick();
        ld_wr_a = 1'b0;
        n = 0;
        while (ld_busy_a && n < 8) begin
          tick();
          n++;
        end
        chk("rnd_busy_timeout", 32'(ld_busy_a), 32'h0);
        ref_a[la] = ldd;
      end
      run_seq_a("rnd", a0, a1, mode == 1, la, ldd);
    end

    // Instance B: four drives, latency 2
    run_seq_b("b_fixed", {15'h7FFF, 15'h4000, 15'h0123, 15'h0001});
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 4; k++) adb[k] = 15'($urandom);
      run_seq_b("b_rnd", adb);
    end

    // Reset in the middle of a sequence with a write pending
    run_seq_a("pre_rst", 15'h0010, 15'h0011, 1'b0, '0, '0);
    drv_addr_a = {15'h0666, 15'h0555};
    ph2_f_a = 1'b1; ld_wr_a = 1'b1; ld_addr_a = 15'h0055; ld_data_a = 8'h3C;
    tick();
    ph2_f_a = 1'b0; ld_wr_a = 1'b0;
    tick();
    chk("mid_busy", 32'(ld_busy_a), 32'h1);
    chk("mid_addr", 32'(mem_addr_a), 32'h0555);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick();
    tick();
    reset = 1'b0;
    exp_a[0] = 8'h00; exp_a[1] = 8'h00;
    for (int k = 0; k < 4; k++) exp_b[k] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      chk("after_rst_we", 32'(mem_we_a), 32'h0);
      tick();
    end
    chk("after_rst_busy", 32'(ld_busy_a), 32'h0);
    run_seq_a("first_after_rst", 15'h0055, 15'h0555, 1'b1, 15'h0056, 8'hC3);
    run_seq_a("final_rd", 15'h0056, 15'h0055, 1'b0, '0, '0);
    run_seq_b("b_after_rst", {15'h0004, 15'h0003, 15'h0002, 15'h0001});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/c1581_rom_arb.md
C1581_ROM_ARB -- requirements
Module: c1581_rom_arb

Interface
REQ-001 SHALL have parameter NDR, default 2, number of drives served, legal range 1..4.
REQ-002 SHALL have parameter ROM_LAT, default 1, ROM read latency in clk cycles from mem_addr to mem_dout, legal range 1..2.
REQ-003 SHALL have port clk  in  1  16 MHz drive clock; one clock only, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port ph2_f  in  1  single-cycle strobe that starts one read sequence.
REQ-006 SHALL have port drv_addr[NDR]  in  15  per-drive ROM address.
REQ-007 SHALL have port drv_data[NDR]  out  8  per-drive ROM data, registered.
REQ-008 SHALL have port mem_addr  out  15  shared ROM address, registered.
REQ-009 SHALL have port mem_din  out  8  shared ROM write data, registered.
REQ-010 SHALL have port mem_we  out  1  shared ROM write enable, registered.
REQ-011 SHALL have port mem_dout  in  8  shared ROM read data.
REQ-012 SHALL have port ld_addr  in  15  loader write address.
REQ-013 SHALL have port ld_data  in  8  loader write data.
REQ-014 SHALL have port ld_wr  in  1  loader write request, single-cycle pulse.
REQ-015 SHALL have port ld_busy  out  1  loader write pending.
REQ-016 SHALL have port seq_err  out  1  one-cycle pulse when ph2_f overruns an active sequence.

Function
REQ-017 SHALL use states IDLE, SEQ and WRITE, with a step counter s that is valid in SEQ.
REQ-018 SHALL, on ph2_f in any state, enter SEQ with s=0 on the next cycle.
REQ-019 SHALL, in SEQ at step s<NDR, register mem_addr<=drv_addr[s] (sampled that cycle) with mem_we=0.
REQ-020 SHALL, in SEQ at step s with LAT_STEP = s-1-ROM_LAT in 0..NDR-1, register drv_data[LAT_STEP]<=mem_dout.
REQ-021 SHALL make the last sequence step s=NDR+ROM_LAT, then go to IDLE, so a sequence is NDR+ROM_LAT+1 cycles long.
REQ-022 SHALL hold each drv_data value constant between its own captures.
REQ-023 SHALL hold mem_addr at its last value while in IDLE.
REQ-024 SHALL, on ph2_f while in SEQ, restart at s=0, pulse seq_err for one cycle, and leave drv_data for uncaptured slots unchanged.
REQ-025 SHALL, on ld_wr while ld_busy=0, latch ld_addr/ld_data into a one-entry buffer and set ld_busy on the next cycle.
REQ-026 SHALL ignore ld_wr while ld_busy=1 (the loader waits for ld_busy low).
REQ-027 SHALL, in IDLE with the buffer pending and no ph2_f, go to WRITE for exactly one cycle with mem_we=1, mem_addr=buffer address, mem_din=buffer data, then clear ld_busy and return to IDLE.
REQ-028 SHALL give ph2_f priority over a pending write in the same cycle; the write waits until the next IDLE.
REQ-029 SHALL never assert mem_we in SEQ; reads and writes never overlap.
REQ-030 SHALL allow ld_wr in the same cycle as ph2_f: the buffer is latched and the write is issued after the sequence.
REQ-031 SHALL ignore drv_addr indexes >= NDR; no port exists for them.

Reset
REQ-032 SHALL, while reset=1, hold state IDLE, s=0, mem_addr=0, mem_din=0, mem_we=0, every drv_data=8'h00, ld_busy=0, seq_err=0, and the write buffer empty.
REQ-033 SHALL let reset mid-sequence or mid-write abort immediately; a pending loader write is discarded.
REQ-034 SHALL, after reset deassertion, ignore nothing: the first ph2_f starts a normal sequence.

Verification
REQ-035 SHALL verify NDR=2, ROM_LAT=1, ROM model, drv_addr={0x0010,0x7FFF}, ph2_f pulse -> mem_addr=0x0010 at ph2_f+2 and 0x7FFF at +3; drv_data[0]=ROM[0x0010] at +4 and drv_data[1]=ROM[0x7FFF] at +5; back in IDLE at +5.
REQ-036 SHALL verify ld_wr(addr 0x1234, data 0xA5) in IDLE -> ld_busy=1 next cycle; one mem_we=1 cycle with mem_addr=0x1234 and mem_din=0xA5; ld_busy=0 after; a subsequent read of 0x1234 returns 0xA5.
REQ-037 SHALL verify ld_wr coincident with ph2_f -> no mem_we during the 4 SEQ cycles; write issued in the first IDLE cycle after; drv_data correct.
REQ-038 SHALL verify a second ph2_f 2 cycles after the first -> seq_err=1 for one cycle; the sequence restarts; final drv_data match the addresses sampled after the restart.
REQ-039 SHALL verify NDR=4, ROM_LAT=2 with distinct addresses -> the sequence takes 7 cycles and each drv_data[k]=ROM[drv_addr[k]].
REQ-040 SHALL verify reset asserted during SEQ with a write pending -> all outputs return to reset values asynchronously; no mem_we after release until a new ld_wr.
